// File: rtl/block_dispatch.sv
// -----------------------------------------------------------------------------
// block_dispatch
//
// Consumer side of the staggered block-release interface. Each rising edge on a
// bit of block_ready becomes exactly one spawn transaction (block index plus a
// pseudo-random screen column) offered to the playfield on a valid/ready
// handshake. Blocks remain marked active from their accepted spawn until the
// playfield retires them with a block_done pulse.
//
// Ports
//   Clk          in   1             system clock
//   Reset        in   1             asynchronous, active-high reset
//   block_ready  in   [0:N-1]       release levels; bit i high = block i released
//   block_done   in   [N-1:0]       one-cycle pulse per bit: block i retired
//   spawn_ready  in   1             playfield accepts the spawn offer this cycle
//   spawn_valid  out  1             spawn offer valid
//   spawn_idx    out  [IW-1:0]      index of the block being spawned
//   spawn_x      out  [X_W-1:0]     spawn column
//   active       out  [N-1:0]       block spawned and not yet retired
//   spawn_count  out  8             accepted spawns, wraps modulo 256
//   all_clear    out  1             registered: something was spawned and nothing
//                                   is active, pending or in flight
// -----------------------------------------------------------------------------
module block_dispatch #(
    parameter int          NUM_BLOCKS  = 5,
    parameter int          X_W         = 10,
    parameter int          X_MIN       = 64,
    parameter int          X_SPAN_LOG2 = 9,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    localparam int         IW          = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic [0:NUM_BLOCKS-1] block_ready,
    input  logic [NUM_BLOCKS-1:0] block_done,
    input  logic                  spawn_ready,
    output logic                  spawn_valid,
    output logic [IW-1:0]         spawn_idx,
    output logic [X_W-1:0]        spawn_x,
    output logic [NUM_BLOCKS-1:0] active,
    output logic [7:0]            spawn_count,
    output logic                  all_clear
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_OFFER = 2'd2
    } state_t;

    state_t                state_reg;
    state_t                state_next;

    logic [NUM_BLOCKS-1:0] ready_q_reg;
    logic [NUM_BLOCKS-1:0] pending_reg;
    logic [NUM_BLOCKS-1:0] pending_next;
    logic [NUM_BLOCKS-1:0] active_reg;
    logic [NUM_BLOCKS-1:0] active_next;
    logic [IW-1:0]         cur_idx_reg;
    logic [X_W-1:0]        spawn_x_reg;
    logic [X_W-1:0]        x_next;
    logic [15:0]           lfsr_reg;
    logic [15:0]           lfsr_next;
    logic [7:0]            count_reg;
    logic                  all_clear_reg;
    logic                  all_clear_next;

    logic [NUM_BLOCKS-1:0] rise;
    logic [NUM_BLOCKS-1:0] held;
    logic [NUM_BLOCKS-1:0] accept;
    logic [NUM_BLOCKS-1:0] cur_onehot;
    logic [NUM_BLOCKS-1:0] low_onehot;
    logic [IW-1:0]         low_idx;
    logic                  load;
    logic                  handshake;

    assign load      = (state_reg == ST_LOAD);
    assign handshake = (state_reg == ST_OFFER) && spawn_ready;

    // Isolate the lowest set pending bit (two's-complement trick).
    assign low_onehot = pending_reg & (~pending_reg + NUM_BLOCKS'(1));

    always_comb begin
        low_idx = '0;
        for (int i = NUM_BLOCKS - 1; i >= 0; i--) begin
            if (pending_reg[i]) begin
                low_idx = IW'(i);
            end
        end
    end

    // Per-block rise detection and admission. A block that is being selected
    // in LOAD or offered in OFFER is treated as busy, so a re-rise of it is
    // dropped rather than producing a duplicate spawn.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_BLOCKS; gi++) begin : g_bit
            assign rise[gi]       = block_ready[gi] & ~ready_q_reg[gi];
            assign cur_onehot[gi] = (cur_idx_reg == IW'(gi));
            assign held[gi]       = (load & low_onehot[gi]) |
                                    ((state_reg == ST_OFFER) & cur_onehot[gi]);
            assign accept[gi]     = rise[gi] & ~pending_reg[gi] & ~active_reg[gi] & ~held[gi];
        end
    endgenerate

    assign pending_next = (pending_reg & ~(load ? low_onehot : '0)) | accept;

    // Handshake set has priority over a same-edge retire of the same block.
    assign active_next = (active_reg & ~block_done) | (handshake ? cur_onehot : '0);

    assign lfsr_next = {1'b0, lfsr_reg[15:1]} ^ (lfsr_reg[0] ? 16'hB400 : 16'h0000);

    // Column = X_MIN + low LFSR bits, wrapped to the output width.
    assign x_next = X_W'(X_MIN) + X_W'(lfsr_reg[X_SPAN_LOG2-1:0]);

    assign all_clear_next = (count_reg != 8'd0) && (active_reg == '0) &&
                            (pending_reg == '0) && (state_reg == ST_IDLE);

    // Next-state and handshake output.
    always_comb begin
        state_next  = state_reg;
        spawn_valid = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (pending_reg != '0) begin
                    state_next = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_next = ST_OFFER;
            end
            ST_OFFER: begin
                spawn_valid = 1'b1;
                if (spawn_ready) begin
                    state_next = (pending_next != '0) ? ST_LOAD : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ready_q_reg   <= '0;
            pending_reg   <= '0;
            active_reg    <= '0;
            cur_idx_reg   <= '0;
            spawn_x_reg   <= '0;
            lfsr_reg      <= LFSR_SEED;
            count_reg     <= 8'd0;
            all_clear_reg <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_BLOCKS; i++) begin
                ready_q_reg[i] <= block_ready[i];
            end
            pending_reg   <= pending_next;
            active_reg    <= active_next;
            lfsr_reg      <= lfsr_next;
            all_clear_reg <= all_clear_next;
            if (load) begin
                cur_idx_reg <= low_idx;
                spawn_x_reg <= x_next;
            end
            if (handshake) begin
                count_reg <= count_reg + 8'd1;
            end
        end
    end

    assign spawn_idx   = cur_idx_reg;
    assign spawn_x     = spawn_x_reg;
    assign active      = active_reg;
    assign spawn_count = count_reg;
    assign all_clear   = all_clear_reg;

endmodule

// File: tb/tb_block_dispatch.sv
// -----------------------------------------------------------------------------
// tb_block_dispatch
//
// Self-checking bench for block_dispatch. A behavioural model built from the
// release/spawn/retire rules (arrays of per-block flags, a stage counter and an
// integer LFSR) is advanced once per clock and compared with every DUT output
// each cycle; directed scenarios add explicit expectations on top, followed by
// a randomized phase.
// -----------------------------------------------------------------------------
module tb_block_dispatch;

    localparam int N  = 5;
    localparam int IW = 3;

    localparam int M_IDLE  = 0;
    localparam int M_LOAD  = 1;
    localparam int M_OFFER = 2;

    logic            Clk;
    logic            Reset;
    logic [0:N-1]    block_ready;
    logic [N-1:0]    block_done;
    logic            spawn_ready;
    logic            spawn_valid;
    logic [IW-1:0]   spawn_idx;
    logic [9:0]      spawn_x;
    logic [N-1:0]    active;
    logic [7:0]      spawn_count;
    logic            all_clear;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    bit          m_pend [N];
    bit          m_act  [N];
    bit          m_prev [N];
    int          m_stage;
    int          m_cur;
    int          m_x;
    int          m_count;
    logic [15:0] m_lfsr;
    bit          m_clear;

    block_dispatch dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .block_ready (block_ready),
        .block_done  (block_done),
        .spawn_ready (spawn_ready),
        .spawn_valid (spawn_valid),
        .spawn_idx   (spawn_idx),
        .spawn_x     (spawn_x),
        .active      (active),
        .spawn_count (spawn_count),
        .all_clear   (all_clear)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    function automatic int lowest_pending();
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) return i;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] pack_active();
        logic [N-1:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_act[i];
        return v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 0;
            m_act[i]  = 0;
            m_prev[i] = 0;
        end
        m_stage = M_IDLE;
        m_cur   = 0;
        m_x     = 0;
        m_count = 0;
        m_lfsr  = 16'hACE1;
        m_clear = 0;
    endtask

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_update();
        bit n_pend [N];
        bit n_act  [N];
        bit hs;
        bit any_pend;
        bit rise;
        bit busy;
        int low;
        bit none_active;

        hs  = (m_stage == M_OFFER) && spawn_ready;
        low = lowest_pending();

        none_active = 1;
        for (int i = 0; i < N; i++) if (m_act[i]) none_active = 0;
        m_clear = (m_count != 0) && none_active && (low < 0) && (m_stage == M_IDLE);

        any_pend = 0;
        for (int i = 0; i < N; i++) begin
            n_pend[i] = m_pend[i];
            if (m_stage == M_LOAD && i == low) n_pend[i] = 0;
            rise = block_ready[i] && !m_prev[i];
            busy = (m_stage == M_LOAD && i == low) || (m_stage == M_OFFER && i == m_cur);
            if (rise && !m_pend[i] && !m_act[i] && !busy) n_pend[i] = 1;
            if (hs && i == m_cur) n_act[i] = 1;
            else if (block_done[i]) n_act[i] = 0;
            else n_act[i] = m_act[i];
            m_prev[i] = block_ready[i];
            if (n_pend[i]) any_pend = 1;
        end

        case (m_stage)
            M_IDLE:  if (low >= 0) m_stage = M_LOAD;
            M_LOAD: begin
                m_cur   = low;
                m_x     = (64 + int'(m_lfsr[8:0])) % 1024;
                m_stage = M_OFFER;
            end
            default: if (hs) m_stage = any_pend ? M_LOAD : M_IDLE;
        endcase

        if (hs) m_count = (m_count + 1) % 256;
        m_lfsr = {1'b0, m_lfsr[15:1]} ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

        for (int i = 0; i < N; i++) begin
            m_pend[i] = n_pend[i];
            m_act[i]  = n_act[i];
        end
    endtask

    task automatic compare_all();
        check("valid",     32'(spawn_valid), 32'(m_stage == M_OFFER));
        check("idx",       32'(spawn_idx),   32'(m_cur));
        check("x",         32'(spawn_x),     32'(m_x));
        check("active",    32'(active),      32'(pack_active()));
        check("count",     32'(spawn_count), 32'(m_count));
        check("all_clear", 32'(all_clear),   32'(m_clear));
    endtask

    task automatic step();
        model_update();
        @(posedge Clk);
        #1;
        compare_all();
    endtask

    task automatic clear_inputs();
        block_ready = '0;
        block_done  = '0;
        spawn_ready = 1'b0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        clear_inputs();
        @(posedge Clk);
        #1;
        model_reset();
        compare_all();
        Reset = 1'b0;
    endtask

    initial begin
        Reset = 1'b1;
        clear_inputs();

        // 1: single release, best-case latency
        do_reset();
        check("t1_rst_valid", 32'(spawn_valid), 32'd0);
        check("t1_rst_count", 32'(spawn_count), 32'd0);
        spawn_ready    = 1'b1;
        block_ready[0] = 1'b1;
        step();
        step();
        check("t1_valid_before", 32'(spawn_valid), 32'd0);
        step();
        check("t1_valid", 32'(spawn_valid), 32'd1);
        check("t1_idx",   32'(spawn_idx),   32'd0);
        check("t1_x",     32'(spawn_x),     32'(m_x));
        step();
        check("t1_active", 32'(active),      32'b00001);
        check("t1_count",  32'(spawn_count), 32'd1);

        // 2: two simultaneous releases, held offer under backpressure
        do_reset();
        spawn_ready    = 1'b0;
        block_ready[0] = 1'b1;
        block_ready[1] = 1'b1;
        step();
        step();
        step();
        for (int c = 0; c < 10; c++) begin
            check("t2_hold_valid", 32'(spawn_valid), 32'd1);
            check("t2_hold_idx",   32'(spawn_idx),   32'd0);
            check("t2_hold_x",     32'(spawn_x),     32'(m_x));
            step();
        end
        spawn_ready = 1'b1;
        step();
        check("t2_active0", 32'(active), 32'b00001);
        step();
        check("t2_idx1",   32'(spawn_idx),   32'd1);
        check("t2_valid1", 32'(spawn_valid), 32'd1);
        step();
        check("t2_active", 32'(active),      32'b00011);
        check("t2_count",  32'(spawn_count), 32'd2);

        // 3: retire block 0, then a redundant retire
        block_done[0] = 1'b1;
        step();
        block_done = '0;
        check("t3_done", 32'(active), 32'b00010);
        block_done[0] = 1'b1;
        step();
        block_done = '0;
        check("t3_redundant", 32'(active), 32'b00010);
        step();

        // 4: re-rise while pending and while active
        do_reset();
        spawn_ready    = 1'b0;
        block_ready[2] = 1'b1;
        step();
        block_ready[2] = 1'b0;
        step();
        block_ready[2] = 1'b1;
        step();
        spawn_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        check("t4_count_pend",  32'(spawn_count), 32'd1);
        check("t4_active_pend", 32'(active),      32'b00100);
        block_ready[2] = 1'b0;
        step();
        block_ready[2] = 1'b1;
        for (int c = 0; c < 4; c++) step();
        check("t4_count_act", 32'(spawn_count), 32'd1);
        check("t4_valid_act", 32'(spawn_valid), 32'd0);

        // 5: staggered full sequence then retire everything
        do_reset();
        spawn_ready = 1'b1;
        for (int b = 0; b < N; b++) begin
            block_ready[b] = 1'b1;
            step();
            step();
            step();
        end
        for (int c = 0; c < 8; c++) step();
        check("t5_count",  32'(spawn_count), 32'd5);
        check("t5_active", 32'(active),      32'b11111);
        check("t5_clear0", 32'(all_clear),   32'd0);
        block_done = '1;
        step();
        block_done = '0;
        check("t5_active_done", 32'(active),    32'd0);
        check("t5_clear_early", 32'(all_clear), 32'd0);
        step();
        check("t5_clear", 32'(all_clear), 32'd1);

        // 6: asynchronous reset in the middle of an offer
        do_reset();
        spawn_ready    = 1'b0;
        block_ready[3] = 1'b1;
        step();
        step();
        step();
        check("t6_offer", 32'(spawn_valid), 32'd1);
        check("t6_idx",   32'(spawn_idx),   32'd3);
        #2;
        Reset = 1'b1;
        #1;
        model_reset();
        check("t6_async_valid", 32'(spawn_valid), 32'd0);
        compare_all();
        clear_inputs();
        @(posedge Clk);
        #1;
        compare_all();
        Reset = 1'b0;
        for (int c = 0; c < 4; c++) step();
        check("t6_dropped", 32'(spawn_count), 32'd0);

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 7) == 0) block_ready[i] = ~block_ready[i];
            end
            block_done = '0;
            if ($urandom_range(0, 3) == 0) begin
                int k;
                k = int'($urandom_range(0, N - 1));
                block_done[k] = 1'b1;
            end
            spawn_ready = 1'($urandom_range(0, 1));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
